ex_stage_alu_mul: RTL
=====================

Name: ex_stage_alu_mul

Overview:
- Execute stage that consumes the ID/EX pipeline buffer outputs: operands, sign-extended immediate, ALU control and destination-register fields.
- Single-cycle ALU ops produce a registered result one cycle later.
- MUL runs on an iterative shift-add multiplier and stalls upstream until it completes.
- Registered outputs feed the EX/MEM buffer.

Parameters:
- DATA_W, 32, operand/result width.
- MUL_BITS, 1, multiplier bits consumed per iteration (1 or 2). MUL iterations = DATA_W/MUL_BITS.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  ID/EX holds a real instruction (0 = bubble).
- flush  in  1  kill current/in-flight op (branch/jump redirect).
- in_alu_op  in  3  operation select.
- in_alu_src  in  1  1 = operand B is in_sign_ext, 0 = in_dr2.
- in_reg_dst  in  1  1 = dest is in_rd, 0 = in_rt.
- in_dr1  in  DATA_W  operand A.
- in_dr2  in  DATA_W  register operand B / store data.
- in_sign_ext  in  DATA_W  sign-extended immediate.
- in_rt  in  5  rt field.
- in_rd  in  5  rd field.
- stall  out  1  upstream must hold ID/EX contents.
- out_valid  out  1  result registers hold a completed instruction.
- out_result  out  DATA_W  ALU/MUL result.
- out_zero  out  1  out_result == 0.
- out_wr_reg  out  5  selected destination register.
- out_store_data  out  DATA_W  registered in_dr2.

Behaviour:
- Reset (async, rst_n=0): all outputs 0, stall=0, FSM=IDLE, iteration counter 0.
- alu_op encoding:
  - 000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLT (signed; result 1 or 0), 101 NOR.
  - 110 MUL: low DATA_W bits of the unsigned product, which equals the signed low word.
  - 111 reserved: result 0, out_valid still asserted.
- Arithmetic wraps modulo 2^DATA_W.
- Single-cycle op with in_valid=1 and FSM=IDLE: on the next edge, register result, zero, wr_reg and store_data; out_valid=1.
- in_valid=0: on the next edge out_valid=0; other outputs hold.
- FSM states IDLE, MUL, DONE:
  - IDLE -> MUL when in_valid & alu_op==110. Capture multiplicand, multiplier, wr_reg and store_data. Clear accumulator, counter=0. out_valid=0 on that edge.
  - MUL: each cycle add shifted partial product(s) for MUL_BITS multiplier bits and increment the counter. After DATA_W/MUL_BITS iterations -> DONE.
  - DONE -> IDLE: register accumulator to out_result; out_valid=1 for exactly one cycle.
- stall: combinational, = (state==IDLE & in_valid & alu_op==110 & !flush) | state==MUL. Deasserted in DONE so the next instruction is accepted on the DONE->IDLE edge.
- MUL latency with MUL_BITS=1: 34 edges from acceptance to out_valid; stall high 33 cycles.
- flush (highest priority):
  - Any state -> IDLE; counter cleared; stall=0 in the same cycle.
  - out_valid=0 on the next edge; in_valid that same cycle is discarded.
- Operand B for MUL follows in_alu_src.
- rst_n low mid-MUL aborts immediately; no output is produced.

Optional Feature:
- Macro EX_OVERFLOW_EN.
- Defined: extra output out_ovf (1 bit), registered with out_result. Set on signed overflow of ADD/SUB; 0 for all other ops, including MUL. Reset value 0.
- Undefined: port absent; no overflow logic.

Decomposition:
- Package ex_pkg:
  - alu_op localparams (ALU_ADD..ALU_RSVD).
  - FSM state encoding (ST_IDLE, ST_MUL, ST_DONE).
  - DATA_W default.
- Sub-module ex_mul_iter: the multiplier datapath and counter. Interface: start, a, b, busy, done, product.
- The top keeps the ALU, muxes, output registers and stall logic.

Test Plan:
- ADD dr1=0x7FFFFFFF, dr2=1, alu_src=0, reg_dst=1, rd=9 -> next cycle out_result=0x80000000, out_wr_reg=9, out_valid=1, out_zero=0. With EX_OVERFLOW_EN: out_ovf=1.
- SUB dr1=5, imm=5, alu_src=1, reg_dst=0, rt=3 -> out_result=0, out_zero=1, out_wr_reg=3. SLT dr1=0xFFFFFFFF, dr2=1 -> out_result=1.
- MUL dr1=0xFFFFFFFF, dr2=3 (MUL_BITS=1) -> stall high 33 cycles; out_result=0xFFFFFFFD with out_valid for one cycle at edge 34. A following ADD issued back-to-back completes on the next edge.
- MUL 1234*0 -> out_result=0, out_zero=1. Repeat with MUL_BITS=2 -> stall high 17 cycles.
- flush asserted on iteration 10 of a MUL -> stall drops the same cycle, out_valid stays 0, FSM IDLE. A new ADD 2+2 is accepted afterwards and gives 4.
- rst_n pulsed low mid-MUL -> all outputs 0 immediately. First op after release: OR 0xF0,0x0F -> 0xFF.

Source files
------------

// File: rtl/ex_pkg.sv
// ----------------------------------------------------------------------------
// ex_pkg
// Shared definitions for the execute stage: ALU operation codes, the
// multi-cycle FSM state encoding and the default datapath width.
// ----------------------------------------------------------------------------
package ex_pkg;

   localparam int DATA_W_DEF = 32;

   localparam logic [2:0] ALU_ADD  = 3'b000;
   localparam logic [2:0] ALU_SUB  = 3'b001;
   localparam logic [2:0] ALU_AND  = 3'b010;
   localparam logic [2:0] ALU_OR   = 3'b011;
   localparam logic [2:0] ALU_SLT  = 3'b100;
   localparam logic [2:0] ALU_NOR  = 3'b101;
   localparam logic [2:0] ALU_MUL  = 3'b110;
   localparam logic [2:0] ALU_RSVD = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DONE = 2'd2
   } ex_state_e;

endpackage

// File: rtl/ex_mul_iter.sv
// ----------------------------------------------------------------------------
// ex_mul_iter
// Iterative shift-add multiplier. Consumes MUL_BITS multiplier bits per cycle
// and produces the low DATA_W bits of the unsigned product after
// DATA_W/MUL_BITS busy cycles.
//
// Ports:
//   clk, rst_n  clock / asynchronous active-low reset
//   start       load operands, clear accumulator and counter
//   abort       drop an in-flight multiply (counter cleared)
//   a, b        multiplicand / multiplier
//   busy        iterations in progress
//   done        high during the final iteration; product valid next cycle
//   product     accumulator (low DATA_W bits of a*b once finished)
// ----------------------------------------------------------------------------
module ex_mul_iter
   import ex_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int MUL_BITS = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] product
);

   localparam int ITER  = DATA_W / MUL_BITS;
   localparam int CNT_W = $clog2(ITER + 1);

   logic [CNT_W-1:0]  cnt;
   logic [DATA_W-1:0] mcand;
   logic [DATA_W-1:0] mplier;
   logic [DATA_W-1:0] acc;
   logic [DATA_W-1:0] pp;

   // Partial product for the MUL_BITS low multiplier bits, built by shift-add.
   always_comb begin
      pp = '0;
      for (int k = 0; k < MUL_BITS; k++) begin
         if (mplier[k]) pp = pp + (mcand << k);
      end
   end

   assign done    = busy && (cnt == CNT_W'(ITER - 1));
   assign product = acc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy <= 1'b0;
         cnt  <= '0;
      end else if (abort) begin
         busy <= 1'b0;
         cnt  <= '0;
      end else if (start) begin
         busy <= 1'b1;
         cnt  <= '0;
      end else if (busy) begin
         if (done) begin
            busy <= 1'b0;
            cnt  <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   // Datapath registers carry no reset: they are only observed after a start.
   always_ff @(posedge clk) begin
      if (start) begin
         mcand  <= a;
         mplier <= b;
         acc    <= '0;
      end else if (busy) begin
         acc    <= acc + pp;
         mcand  <= mcand << MUL_BITS;
         mplier <= mplier >> MUL_BITS;
      end
   end

endmodule

// File: rtl/ex_stage_alu_mul.sv
// ----------------------------------------------------------------------------
// ex_stage_alu_mul
// Execute stage: single-cycle ALU plus an iterative multiplier that stalls
// the ID/EX buffer while it runs. All results are registered for EX/MEM.
// Optional feature macro: EX_OVERFLOW_EN adds out_ovf (signed ADD/SUB
// overflow, registered with out_result).
//
// Ports:
//   clk, rst_n       clock / asynchronous active-low reset
//   in_valid, flush  instruction present / redirect kill
//   in_alu_op, in_alu_src, in_reg_dst, in_dr1, in_dr2, in_sign_ext,
//   in_rt, in_rd     ID/EX buffer fields
//   stall            hold ID/EX contents (combinational)
//   out_valid, out_result, out_zero, out_wr_reg, out_store_data
//                    registered EX/MEM fields
//   out_ovf          (EX_OVERFLOW_EN only) signed overflow of ADD/SUB
// ----------------------------------------------------------------------------
module ex_stage_alu_mul
   import ex_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int MUL_BITS = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic              flush,
   input  logic [2:0]        in_alu_op,
   input  logic              in_alu_src,
   input  logic              in_reg_dst,
   input  logic [DATA_W-1:0] in_dr1,
   input  logic [DATA_W-1:0] in_dr2,
   input  logic [DATA_W-1:0] in_sign_ext,
   input  logic [4:0]        in_rt,
   input  logic [4:0]        in_rd,
   output logic              stall,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_result,
   output logic              out_zero,
`ifdef EX_OVERFLOW_EN
   output logic              out_ovf,
`endif
   output logic [4:0]        out_wr_reg,
   output logic [DATA_W-1:0] out_store_data
);

   function automatic logic [DATA_W-1:0] alu_f(input logic [2:0]        op,
                                                input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
      logic signed [DATA_W-1:0] sa;
      logic signed [DATA_W-1:0] sb;
      sa = a;
      sb = b;
      case (op)
         ALU_ADD: alu_f = a + b;
         ALU_SUB: alu_f = a - b;
         ALU_AND: alu_f = a & b;
         ALU_OR:  alu_f = a | b;
         ALU_SLT: alu_f = (sa < sb) ? DATA_W'(1) : '0;
         ALU_NOR: alu_f = ~(a | b);
         ALU_RSVD: alu_f = '0;
         default: alu_f = '0;  // MUL result comes from the iterative unit
      endcase
   endfunction

`ifdef EX_OVERFLOW_EN
   function automatic logic ovf_f(input logic [2:0]        op,
                                  input logic [DATA_W-1:0] a,
                                  input logic [DATA_W-1:0] b,
                                  input logic [DATA_W-1:0] r);
      case (op)
         ALU_ADD: ovf_f = (a[DATA_W-1] == b[DATA_W-1]) && (r[DATA_W-1] != a[DATA_W-1]);
         ALU_SUB: ovf_f = (a[DATA_W-1] != b[DATA_W-1]) && (r[DATA_W-1] != a[DATA_W-1]);
         default: ovf_f = 1'b0;
      endcase
   endfunction
`endif

   ex_state_e         state;
   logic [DATA_W-1:0] op_b;
   logic [4:0]        wr_sel;
   logic [DATA_W-1:0] alu_res;
   logic              mul_start;
   logic              mul_busy;
   logic              mul_done;
   logic [DATA_W-1:0] mul_product;
   logic [4:0]        cap_wr_reg;
   logic [DATA_W-1:0] cap_store;

   assign op_b      = in_alu_src ? in_sign_ext : in_dr2;
   assign wr_sel    = in_reg_dst ? in_rd : in_rt;
   assign alu_res   = alu_f(in_alu_op, in_dr1, op_b);
   assign mul_start = (state == ST_IDLE) && in_valid && (in_alu_op == ALU_MUL) && !flush;

   // Flush wins the same cycle; stall is also held low while in reset.
   // The multiplier is busy exactly while the FSM sits in ST_MUL.
   assign stall = rst_n && !flush && (mul_start || ((state == ST_MUL) && mul_busy));

   ex_mul_iter #(
      .DATA_W   (DATA_W),
      .MUL_BITS (MUL_BITS)
   ) u_mul (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (mul_start),
      .abort   (flush),
      .a       (in_dr1),
      .b       (op_b),
      .busy    (mul_busy),
      .done    (mul_done),
      .product (mul_product)
   );

   // Destination and store data of the MUL held until its result retires.
   always_ff @(posedge clk) begin
      if (mul_start) begin
         cap_wr_reg <= wr_sel;
         cap_store  <= in_dr2;
      end
   end

   // ---- EX/MEM output stage ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= ST_IDLE;
         out_valid      <= 1'b0;
         out_result     <= '0;
         out_zero       <= 1'b0;
         out_wr_reg     <= '0;
         out_store_data <= '0;
`ifdef EX_OVERFLOW_EN
         out_ovf        <= 1'b0;
`endif
      end else if (flush) begin
         state     <= ST_IDLE;
         out_valid <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid && (in_alu_op == ALU_MUL)) begin
                  state     <= ST_MUL;
                  out_valid <= 1'b0;
               end else if (in_valid) begin
                  out_valid      <= 1'b1;
                  out_result     <= alu_res;
                  out_zero       <= (alu_res == '0);
                  out_wr_reg     <= wr_sel;
                  out_store_data <= in_dr2;
`ifdef EX_OVERFLOW_EN
                  out_ovf        <= ovf_f(in_alu_op, in_dr1, op_b, alu_res);
`endif
               end else begin
                  out_valid <= 1'b0;
               end
            end
            ST_MUL: begin
               out_valid <= 1'b0;
               if (mul_done) state <= ST_DONE;
            end
            ST_DONE: begin
               state          <= ST_IDLE;
               out_valid      <= 1'b1;
               out_result     <= mul_product;
               out_zero       <= (mul_product == '0);
               out_wr_reg     <= cap_wr_reg;
               out_store_data <= cap_store;
`ifdef EX_OVERFLOW_EN
               out_ovf        <= 1'b0;
`endif
            end
            default: begin
               state     <= ST_IDLE;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
